jump_target_unit: RTL and testbench
===================================

JUMP_TARGET_UNIT -- requirements
Module: jump_target_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width in bits.
REQ-002 The block SHALL have parameter IMM_W, default 26, meaning jump/branch immediate width.
REQ-003 The block SHALL have parameter SHIFT, default 2, meaning the immediate left-shift amount (word alignment).
REQ-004 The block SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of 2, >=2).
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock (all state on rising edge).
REQ-006 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port valid_in, input, 1, meaning a control-transfer op is presented this cycle.
REQ-008 The block SHALL have port mode, input, 2, meaning 00 J, 01 JAL, 10 JR, 11 BR.
REQ-009 The block SHALL have port pc_plus4, input, ADDR_W, meaning the address of the next sequential instruction.
REQ-010 The block SHALL have port imm, input, IMM_W, meaning the jump index (J/JAL) or signed branch offset (BR).
REQ-011 The block SHALL have port reg_target, input, ADDR_W, meaning the register operand for JR.
REQ-012 The block SHALL have port flush, input, 1, meaning clear the RAS.
REQ-013 The block SHALL have port target_valid, output, 1, meaning target/flags valid this cycle.
REQ-014 The block SHALL have port target, output, ADDR_W, meaning the computed next-PC.
REQ-015 The block SHALL have ports ras_hit, misalign, ras_overflow and ras_underflow, each an output of width 1, meaning per-op status pulses.

Function
REQ-016 Outputs SHALL be registered with 1-cycle latency: an op accepted at edge N appears at edge N+1 with target_valid=1.
REQ-017 When valid_in=0, target_valid and all status pulses SHALL be 0 next cycle, target SHALL hold, and the RAS SHALL be unchanged.
REQ-018 J SHALL produce target = {pc_plus4[ADDR_W-1:IMM_W+SHIFT], imm, SHIFT zeros}; elaboration SHALL fail if ADDR_W < IMM_W+SHIFT.
REQ-019 JAL SHALL produce the J target and push pc_plus4 onto the RAS.
REQ-020 BR SHALL produce target = pc_plus4 + (sign-extended imm << SHIFT), truncated modulo 2^ADDR_W.
REQ-021 JR SHALL produce target = reg_target, pop the RAS, and set ras_hit=1 iff the RAS was non-empty and the popped entry equals reg_target.
REQ-022 misalign SHALL be 1 iff target[SHIFT-1:0] != 0; target SHALL still be output unmodified.
REQ-023 A JAL with the RAS full SHALL overwrite the oldest entry (circular), keep count=RAS_DEPTH, and pulse ras_overflow.
REQ-024 A JR with the RAS empty SHALL pulse ras_underflow, force ras_hit=0, and leave the pointer unchanged.
REQ-025 flush SHALL set the RAS count to 0 at the next edge; with flush and valid_in in the same cycle, the target SHALL be computed normally, the op's push/pop SHALL be discarded, and ras_hit/underflow/overflow SHALL be 0.

Reset
REQ-026 rst_n low SHALL immediately force target_valid, target, ras_hit, misalign, ras_overflow, ras_underflow, the RAS pointer and the RAS count to 0, including mid-sequence.
REQ-027 RAS entry storage SHALL need no reset; empty-state logic SHALL guarantee it is never read.

Structure
REQ-028 A shared package jump_pkg SHALL hold the mode enum (J/JAL/JR/BR) and the default parameter constants.
REQ-029 The RAS SHALL be one sub-module, ras_stack (push, pop, clear, top, empty, full), instantiated once.

Verification (ADDR_W=32, IMM_W=26, SHIFT=2, RAS_DEPTH=4)
REQ-030 Scenario J: pc_plus4=0x1000_0004, imm=0x0000100 -> next cycle target=0x1000_0400, target_valid=1, misalign=0.
REQ-031 Scenario BR: pc_plus4=0x0000_0100, imm=0x3FF_FFFF (-1) -> target=0x0000_00FC.
REQ-032 Scenario RAS: 5 JALs with pc_plus4=0x10,0x20,0x30,0x40,0x50 -> ras_overflow on the 5th only; then 5 JRs with matching reg_target -> pops 0x50,0x40,0x30,0x20 with ras_hit=1; the 5th JR gives ras_underflow=1, ras_hit=0.
REQ-033 Scenario misalign: JR with reg_target=0x0000_0102 -> target=0x0000_0102, misalign=1.
REQ-034 Scenario reset/flush: after 2 JALs, drop rst_n mid-cycle -> outputs 0 immediately and the next JR underflows; after release, JAL with flush in the same cycle -> valid target, and a following JR underflows.

Source files
------------

// File: rtl/jump_pkg.sv
// Shared definitions for the jump target unit: control-transfer mode encoding
// and default parameter values.
package jump_pkg;

    typedef enum logic [1:0] {
        MODE_J   = 2'b00,
        MODE_JAL = 2'b01,
        MODE_JR  = 2'b10,
        MODE_BR  = 2'b11
    } mode_e;

    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_IMM_W     = 26;
    localparam int unsigned DEF_SHIFT     = 2;
    localparam int unsigned DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// a pop when empty leaves the pointer alone. Entry storage is never reset.
module ras_stack
    import jump_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ras_stack: DEPTH must be a power of 2 and >= 2");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]  top_idx;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
    // ptr_q is the next write slot, so the most recent entry sits one below it
    assign top_idx = ptr_q - PTR_W'(1);
    assign top     = mem_q[top_idx];

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (!full) cnt_d = cnt_q + (PTR_W + 1)'(1);
        end else if (pop && !empty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[ptr_q] <= push_data;
    end

endmodule

// File: rtl/jump_target_unit.sv
// Next-PC computation for J/JAL/JR/BR with a return-address stack for
// JAL/JR prediction checking. All outputs are registered (1-cycle latency).
module jump_target_unit
    import jump_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned IMM_W     = DEF_IMM_W,
    parameter int unsigned SHIFT     = DEF_SHIFT,
    parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              flush,
    output logic              target_valid,
    output logic [ADDR_W-1:0] target,
    output logic              ras_hit,
    output logic              misalign,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    if (ADDR_W < IMM_W + SHIFT) begin : g_bad_width
        $error("jump_target_unit: ADDR_W must be >= IMM_W + SHIFT");
    end

    // Masks instead of slices so SHIFT=0 and ADDR_W==IMM_W+SHIFT stay legal
    localparam logic [ADDR_W-1:0] HI_MASK = ~((ADDR_W'(1) << (IMM_W + SHIFT)) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] LO_MASK = (ADDR_W'(1) << SHIFT) - ADDR_W'(1);

    mode_e             mode_s;
    logic [ADDR_W-1:0] j_target, br_off;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty, ras_full, ras_push, ras_pop;

    logic              target_valid_q, target_valid_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              ras_hit_q, ras_hit_d;
    logic              misalign_q, misalign_d;
    logic              ras_overflow_q, ras_overflow_d;
    logic              ras_underflow_q, ras_underflow_d;

    assign mode_s   = mode_e'(mode);
    assign j_target = (pc_plus4 & HI_MASK) | (ADDR_W'(imm) << SHIFT);
    assign br_off   = ADDR_W'($signed(imm)) << SHIFT;
    // A flushed op still produces its target but never touches the stack
    assign ras_push = valid_in && !flush && (mode_s == MODE_JAL);
    assign ras_pop  = valid_in && !flush && (mode_s == MODE_JR);

    ras_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (flush),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_comb begin
        target_valid_d  = valid_in;
        target_d        = target_q;
        ras_hit_d       = 1'b0;
        misalign_d      = 1'b0;
        ras_overflow_d  = 1'b0;
        ras_underflow_d = 1'b0;
        if (valid_in) begin
            case (mode_s)
                MODE_J:   target_d = j_target;
                MODE_JAL: target_d = j_target;
                MODE_JR:  target_d = reg_target;
                MODE_BR:  target_d = pc_plus4 + br_off;
                default:  target_d = target_q;
            endcase
            misalign_d      = |(target_d & LO_MASK);
            ras_overflow_d  = ras_push && ras_full;
            ras_underflow_d = ras_pop && ras_empty;
            ras_hit_d       = ras_pop && !ras_empty && (ras_top == reg_target);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_valid_q  <= 1'b0;
            target_q        <= '0;
            ras_hit_q       <= 1'b0;
            misalign_q      <= 1'b0;
            ras_overflow_q  <= 1'b0;
            ras_underflow_q <= 1'b0;
        end else begin
            target_valid_q  <= target_valid_d;
            target_q        <= target_d;
            ras_hit_q       <= ras_hit_d;
            misalign_q      <= misalign_d;
            ras_overflow_q  <= ras_overflow_d;
            ras_underflow_q <= ras_underflow_d;
        end
    end

    assign target_valid  = target_valid_q;
    assign target        = target_q;
    assign ras_hit       = ras_hit_q;
    assign misalign      = misalign_q;
    assign ras_overflow  = ras_overflow_q;
    assign ras_underflow = ras_underflow_q;

endmodule

// File: tb/tb_jump_target_unit.sv
// Bench for jump_target_unit: directed scenarios plus random ops against a
// queue-based model of the return-address stack.
module tb_jump_target_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] pc_plus4 = '0;
    logic [25:0] imm = '0;
    logic [31:0] reg_target = '0;
    logic        flush = 1'b0;
    logic        target_valid;
    logic [31:0] target;
    logic        ras_hit, misalign, ras_overflow, ras_underflow;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] ras_q[$];
    logic [31:0] exp_target = '0;

    always #5 clk = ~clk;

    jump_target_unit #(
        .ADDR_W(32), .IMM_W(26), .SHIFT(2), .RAS_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .mode          (mode),
        .pc_plus4      (pc_plus4),
        .imm           (imm),
        .reg_target    (reg_target),
        .flush         (flush),
        .target_valid  (target_valid),
        .target        (target),
        .ras_hit       (ras_hit),
        .misalign      (misalign),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, ".vld"}, 32'(target_valid), 0);
        chk({tag, ".tgt"}, target, 0);
        chk({tag, ".hit"}, 32'(ras_hit), 0);
        chk({tag, ".mis"}, 32'(misalign), 0);
        chk({tag, ".ovf"}, 32'(ras_overflow), 0);
        chk({tag, ".udf"}, 32'(ras_underflow), 0);
    endtask

    // Drive one op for one cycle; model its effect and check the registered result.
    task automatic op(input string tag, input logic v, input logic [1:0] m,
                      input logic [31:0] pc, input logic [25:0] im,
                      input logic [31:0] rt, input logic fl);
        logic e_hit, e_ovf, e_udf, e_mis;
        logic [31:0] off;
        valid_in = v; mode = m; pc_plus4 = pc; imm = im; reg_target = rt; flush = fl;
        e_hit = 0; e_ovf = 0; e_udf = 0; e_mis = 0;
        if (v) begin
            case (m)
                2'b00, 2'b01: exp_target = {pc[31:28], im, 2'b00};
                2'b10:        exp_target = rt;
                default: begin
                    off = {{6{im[25]}}, im};
                    exp_target = pc + off * 4;
                end
            endcase
            e_mis = (exp_target % 4) != 0;
            if (!fl && m == 2'b01) begin
                if (ras_q.size() == 4) begin
                    e_ovf = 1;
                    void'(ras_q.pop_front());
                end
                ras_q.push_back(pc);
            end else if (!fl && m == 2'b10) begin
                if (ras_q.size() == 0) e_udf = 1;
                else e_hit = (ras_q.pop_back() == rt);
            end
        end
        if (fl) ras_q.delete();
        @(posedge clk);
        #1;
        chk({tag, ".vld"}, 32'(target_valid), 32'(v));
        chk({tag, ".tgt"}, target, exp_target);
        chk({tag, ".hit"}, 32'(ras_hit), 32'(e_hit));
        chk({tag, ".mis"}, 32'(misalign), 32'(e_mis));
        chk({tag, ".ovf"}, 32'(ras_overflow), 32'(e_ovf));
        chk({tag, ".udf"}, 32'(ras_underflow), 32'(e_udf));
        valid_in = 0; flush = 0;
    endtask

    initial begin
        #1;
        chk_outs_zero("reset");
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: J, BR, misalign
        op("j",   1, 2'b00, 32'h1000_0004, 26'h000_0100, 0, 0);
        chk("j.abs", target, 32'h1000_0400);
        op("br",  1, 2'b11, 32'h0000_0100, 26'h3FF_FFFF, 0, 0);
        chk("br.abs", target, 32'h0000_00FC);
        op("idle", 0, 2'b11, 32'hDEAD_BEEC, 26'h155_5555, 0, 0);
        op("jr_mis", 1, 2'b10, 0, 0, 32'h0000_0102, 0);
        chk("jr_mis.abs", 32'(misalign), 1);
        op("jr_udf0", 1, 2'b10, 0, 0, 32'h0000_0102, 0);

        // RAS overflow/underflow
        for (int i = 1; i <= 5; i++)
            op($sformatf("jal%0d", i), 1, 2'b01, 32'(i * 16), 26'(i), 0, 0);
        chk("jal5.ovf.abs", 32'(ras_overflow), 1);
        for (int i = 5; i >= 1; i--)
            op($sformatf("jr%0d", i), 1, 2'b10, 0, 0, 32'(i * 16), 0);
        chk("jr1.udf.abs", 32'(ras_underflow), 1);

        // Mid-cycle reset after two JALs
        op("rjal1", 1, 2'b01, 32'h0000_0200, 26'h10, 0, 0);
        op("rjal2", 1, 2'b01, 32'h0000_0300, 26'h20, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_outs_zero("rst_mid");
        ras_q.delete();
        exp_target = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op("rst_jr", 1, 2'b10, 0, 0, 32'h0000_0300, 0);

        // Flush with a JAL in the same cycle discards the push
        op("pre_jal", 1, 2'b01, 32'h0000_0400, 26'h40, 0, 0);
        op("fl_jal", 1, 2'b01, 32'h0000_0500, 26'h80, 0, 1);
        op("fl_jr",  1, 2'b10, 0, 0, 32'h0000_0500, 0);
        op("fl_jr_idle", 0, 2'b00, 0, 0, 0, 1);

        // Random ops
        for (int n = 0; n < 400; n++) begin
            logic        v, fl;
            logic [1:0]  m;
            logic [31:0] pc, rt;
            logic [25:0] im;
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 15) == 0);
            m  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0 && ras_q.size() < 3) m = 2'b01;
            pc = $urandom & 32'hFFFF_FFFC;
            im = 26'($urandom);
            rt = $urandom;
            if ($urandom_range(0, 3) != 0) rt = rt & 32'hFFFF_FFFC;
            if (ras_q.size() > 0 && $urandom_range(0, 2) != 0) rt = ras_q[ras_q.size() - 1];
            op($sformatf("rnd%0d", n), v, m, pc, im, rt, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
